// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave register file with independent AW/W buffering, byte strobes,
// read-only hardware-status registers and SLVERR on illegal accesses.
module axil_regfile_slave #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int HI_LSB   = ADDR_LSB + IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("axil_regfile_slave: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 2 || NUM_REGS > 256 || (1 << IDX_W) != NUM_REGS) begin : g_bad_regs
    $error("axil_regfile_slave: NUM_REGS must be a power of two in 2..256");
  end

  logic                  r_awFull;
  logic [ADDR_WIDTH-1:0] r_awAddr;
  logic                  r_wFull;
  logic [DATA_WIDTH-1:0] r_wData;
  logic [STRB_WIDTH-1:0] r_wStrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_arHs;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_awIdx;
  logic [IDX_W-1:0]      w_arIdx;
  logic                  w_awOor;
  logic                  w_arOor;
  logic                  w_wrLegal;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_hw   [NUM_REGS];
  logic                  w_unused;

  assign s_axil_awready = !rst && !r_awFull;
  assign s_axil_wready  = !rst && !r_wFull;
  assign s_axil_arready = !rst && !r_rvalid;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;

  assign w_awHs   = s_axil_awvalid && s_axil_awready;
  assign w_wHs    = s_axil_wvalid && s_axil_wready;
  assign w_arHs   = s_axil_arvalid && s_axil_arready;
  // A commit waits for the previous response to drain so bresp is never overwritten.
  assign w_commit = r_awFull && r_wFull && !r_bvalid;

  assign w_awIdx  = r_awAddr[ADDR_LSB +: IDX_W];
  assign w_arIdx  = s_axil_araddr[ADDR_LSB +: IDX_W];

  if (HI_LSB < ADDR_WIDTH) begin : g_hi_bits
    assign w_awOor = |r_awAddr[ADDR_WIDTH-1:HI_LSB];
    assign w_arOor = |s_axil_araddr[ADDR_WIDTH-1:HI_LSB];
  end else begin : g_no_hi_bits
    assign w_awOor = 1'b0;
    assign w_arOor = 1'b0;
  end

  assign w_wrLegal = !w_awOor && !RO_MASK[w_awIdx];

  // Byte-lane address bits and the protection fields carry no meaning here.
  assign w_unused = ^{s_axil_awprot, s_axil_arprot,
                      r_awAddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awFull <= 1'b0;
      r_awAddr <= '0;
    end else if (w_awHs) begin
      r_awFull <= 1'b1;
      r_awAddr <= s_axil_awaddr;
    end else if (w_commit) begin
      r_awFull <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wFull <= 1'b0;
      r_wData <= '0;
      r_wStrb <= '0;
    end else if (w_wHs) begin
      r_wFull <= 1'b1;
      r_wData <= s_axil_wdata;
      r_wStrb <= s_axil_wstrb;
    end else if (w_commit) begin
      r_wFull <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wrLegal ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && s_axil_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read-only slots hold no storage; they always present zero on reg_q.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign w_hw[i] = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = w_regs[i];

    if (RO_MASK[i]) begin : g_ro
      assign w_regs[i] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_commit && w_wrLegal && (w_awIdx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (r_wStrb[b]) begin
              r_q[8*b +: 8] <= r_wData[8*b +: 8];
            end
          end
        end
      end

      assign w_regs[i] = r_q;
    end
  end

  // Nonblocking capture gives the pre-write value when a commit lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_arHs) begin
      r_rvalid <= 1'b1;
      if (w_arOor) begin
        r_rdata <= '0;
        r_rresp <= RESP_SLVERR;
      end else begin
        r_rdata <= RO_MASK[w_arIdx] ? w_hw[w_arIdx] : w_regs[w_arIdx];
        r_rresp <= RESP_OKAY;
      end
    end else if (r_rvalid && s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/axil_regfile_slave.md
# axil_regfile_slave

Parametrised AXI4-Lite slave register file: the next-generation DUT behind the `Intf` AXI4-Lite bench. It adds:
- configurable data width and register count;
- independent AW/W channel acceptance;
- byte-strobe writes;
- read-only hardware-status registers;
- SLVERR responses for illegal accesses.

It sits between the AXI4-Lite master (UVM agent) and downstream control/status logic.

## Interface
- DATA_WIDTH, 32, data bus width; 32 or 64 only
- ADDR_WIDTH, 32, address bus width
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- NUM_REGS, 16, number of registers; power of two, 2..256
- RO_MASK, 0 (NUM_REGS bits), bit i set = register i is read-only and reads hw_in slice i

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid / s_axil_awready  in / out  1  write-address handshake
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  STRB_WIDTH  byte enables
- s_axil_wvalid / s_axil_wready  in / out  1  write-data handshake
- s_axil_bresp  out  2  write response
- s_axil_bvalid / s_axil_bready  out / in  1  write-response handshake
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid / s_axil_arready  in / out  1  read-address handshake
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid / s_axil_rready  out / in  1  read-data handshake
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; slice i = register i
- hw_in  in  NUM_REGS*DATA_WIDTH  hardware values returned for read-only registers

## Operation

**Address decode**
- ADDR_LSB = log2(STRB_WIDTH); index = addr[ADDR_LSB +: log2(NUM_REGS)].
- Address bits below ADDR_LSB are ignored.
- Any set bit above the index field marks the access out-of-range.

**Write path**
- AW and W each have a one-entry holding buffer.
- awready = !rst && AW buffer empty; wready = !rst && W buffer empty. The two are accepted in any order or in the same cycle.
- Commit happens when both buffers are full and bvalid = 0:
  - Legal, writable index: each byte with wstrb[b]=1 is updated; bresp = OKAY (2'b00).
  - Out-of-range or RO_MASK index: no register changes; bresp = SLVERR (2'b10).
  - wstrb = 0 to a legal register: no change; bresp = OKAY.
  - Both buffers are emptied and bvalid = 1.
- bvalid and bresp stay stable until bready; bvalid clears on the bvalid && bready edge.
- A new AW/W may be buffered while bvalid is pending; its commit waits until bvalid = 0.

**Read path**
- arready = !rst && !rvalid.
- On the AR handshake, rdata/rresp are registered and rvalid = 1:
  - Writable register: its current value, rresp = OKAY.
  - RO register: hw_in slice sampled at the handshake edge, rresp = OKAY.
  - Out-of-range: rdata = 0, rresp = SLVERR.
- rdata, rresp and rvalid stay stable until rready; rvalid clears on the rvalid && rready edge.

**Simultaneous events**
- A read handshake on the same edge as a write commit to the same register returns the pre-write value.
- Read and write paths are fully independent.

**Reset**
- Every register = 0.
- Buffers empty.
- All outputs 0: readies, bvalid, bresp, rvalid, rdata, rresp, reg_q.
- Reset asserted mid-transaction drops all pending transactions; no response is issued for them.

## Timing
- Write latency: the commit edge is 1 cycle after the later of the AW/W handshakes; bvalid is high after that edge, and reg_q updates on the same edge.
- With bready tied high, sustained write throughput is 1 per 2 cycles.
- Read latency: rvalid is high the cycle after the AR handshake.
- With rready tied high, sustained read throughput is 1 per 2 cycles, since arready is low while rvalid is high.
- The first handshake is possible in the first cycle with rst = 0.

## Test plan
Configuration for all scenarios: DATA_WIDTH=32, NUM_REGS=16, RO_MASK=16'h8000.
- Reset, then write addr 0x08 data 0xDEADBEEF strb 0xF, then read 0x08 -> bresp 00, rdata 0xDEADBEEF, reg_q[95:64] = 0xDEADBEEF.
- W presented 3 cycles before AW (addr 0x04, data 0x11223344, strb 0x5) onto reset value 0 -> wready drops after the W handshake; a single bvalid occurs 1 cycle after the AW handshake; register 1 = 0x00220044.
- Write to 0x3C (RO) and to 0x40 (out-of-range), each with data 0xFFFFFFFF -> both return bresp 10 and no reg_q change. Read 0x3C with hw_in[511:480]=0xCAFE0001 -> rdata 0xCAFE0001, rresp 00. Read 0x40 -> rdata 0, rresp 10.
- Hold bready and rready low for 5 cycles after bvalid/rvalid -> bresp, rdata and rresp remain stable, arready stays 0, and a second buffered write does not commit until bready is high.
- Issue the AR handshake to 0x00 on the same edge as the commit of a write 0x55 to 0x00 (previous value 0x12) -> rdata 0x12; a subsequent read returns 0x55.
- Assert rst while AW is buffered and bvalid is pending -> next cycle all outputs are 0; bvalid never asserts for the dropped write; register contents are 0.
